// File: rtl/mem_port_arbiter.sv
// Unified-memory port arbiter between instruction fetch (IF) and data access (DM).
// Fixed-latency memory; DM has priority, with a starvation guard that forces IF ahead.
//
// state   | meaning
// --------+------------------------------------------------------
// IDLE    | no access in flight, arbitrating every cycle
// BUSY_IF | IF read in flight, address mux on IF (addr_sel = 0)
// BUSY_DM | DM access in flight, address mux on DM (addr_sel = 1)
module mem_port_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3,
  parameter int CNT_W      = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic dm_req,
  input  logic dm_we,
  output logic addr_sel,
  output logic mem_en,
  output logic mem_we,
  output logic if_ack,
  output logic dm_ack,
  output logic if_stall,
  output logic dm_stall
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAT_C    = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] STARVE_C = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  state_t           state, state_d;
  logic [CNT_W-1:0] lat_cnt;
  logic [CNT_W-1:0] starve_cnt;
  logic             we_q;

  logic busy, done, arb;
  logic if_eff, dm_eff;
  logic grant_if, grant_dm;

  assign busy = (state != IDLE);
  assign done = busy && (lat_cnt == LAT_C);
  assign arb  = !busy || done;

  // The requester being acked this cycle is not eligible to win again.
  assign if_eff = if_req && !((state == BUSY_IF) && done);
  assign dm_eff = dm_req && !((state == BUSY_DM) && done);

  always_comb begin
    state_d  = state;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (arb) begin
      state_d = IDLE;
      if (dm_eff && !(if_eff && (starve_cnt == STARVE_C))) begin
        grant_dm = 1'b1;
        state_d  = BUSY_DM;
      end else if (if_eff) begin
        grant_if = 1'b1;
        state_d  = BUSY_IF;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      we_q       <= 1'b0;
    end else begin
      state <= state_d;

      if (grant_if || grant_dm) begin
        lat_cnt <= ONE_C;
        we_q    <= grant_dm && dm_we;
      end else if (done) begin
        lat_cnt <= '0;
      end else if (busy) begin
        lat_cnt <= lat_cnt + ONE_C;
      end

      // Counts DM wins taken while IF was asking; saturates at the guard level.
      if (grant_if) begin
        starve_cnt <= '0;
      end else if (grant_dm && if_req && (starve_cnt != STARVE_C)) begin
        starve_cnt <= starve_cnt + ONE_C;
      end
    end
  end

  assign addr_sel = (state == BUSY_DM);
  assign mem_en   = busy && (lat_cnt == ONE_C);
  assign mem_we   = (state == BUSY_DM) && (lat_cnt == ONE_C) && we_q;
  assign if_ack   = (state == BUSY_IF) && done;
  assign dm_ack   = (state == BUSY_DM) && done;
  assign if_stall = if_req && !if_ack;
  assign dm_stall = dm_req && !dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a MEM_LAT=2 instance (a) and a MEM_LAT=1 instance (b)
// share inputs; output vectors are {addr_sel, mem_en, mem_we, if_ack, dm_ack, if_stall, dm_stall}.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic if_req, dm_req, dm_we;

  logic a_sel, a_en, a_we, a_iack, a_dack, a_ist, a_dst;
  logic b_sel, b_en, b_we, b_iack, b_dack, b_ist, b_dst;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(3), .CNT_W(4)) u_dut_a (
    .clk(clk), .rst(rst), .if_req(if_req), .dm_req(dm_req), .dm_we(dm_we),
    .addr_sel(a_sel), .mem_en(a_en), .mem_we(a_we), .if_ack(a_iack), .dm_ack(a_dack),
    .if_stall(a_ist), .dm_stall(a_dst)
  );

  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(3), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst(rst), .if_req(if_req), .dm_req(dm_req), .dm_we(dm_we),
    .addr_sel(b_sel), .mem_en(b_en), .mem_we(b_we), .if_ack(b_iack), .dm_ack(b_dack),
    .if_stall(b_ist), .dm_stall(b_dst)
  );

  wire [6:0] oa = {a_sel, a_en, a_we, a_iack, a_dack, a_ist, a_dst};
  wire [6:0] ob = {b_sel, b_en, b_we, b_iack, b_dack, b_ist, b_dst};

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Start a new cycle: step past the rising edge, drive inputs, let them settle.
  task automatic cyc(input logic i, input logic d, input logic w);
    @(posedge clk);
    #1;
    if_req = i;
    dm_req = d;
    dm_we  = w;
    #3;
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    #3;
    chk("reset_a", oa, 7'b0000000);
    chk("reset_b", ob, 7'b0000000);
    @(posedge clk); #1; rst = 1'b0;

    // IF read alone
    cyc(1, 0, 0); chk("if_c0", oa, 7'b0000010);
    cyc(1, 0, 0); chk("if_c1", oa, 7'b0100010);
    cyc(0, 0, 0); chk("if_c2_ack", oa, 7'b0001000);
    cyc(0, 0, 0); chk("if_c3_idle", oa, 7'b0000000);

    // DM write; dm_we changes after grant and must not affect mem_we
    cyc(0, 1, 1); chk("dmw_c0", oa, 7'b0000001);
    cyc(0, 1, 0); chk("dmw_c1", oa, 7'b1110001);
    cyc(0, 0, 0); chk("dmw_c2_ack", oa, 7'b1000100);
    cyc(0, 0, 0); chk("dmw_c3_idle", oa, 7'b0000000);

    // DM request pulsed for a single cycle still completes
    cyc(0, 1, 0); chk("dmp_c0", oa, 7'b0000001);
    cyc(0, 0, 0); chk("dmp_c1", oa, 7'b1100000);
    cyc(0, 0, 0); chk("dmp_c2_ack", oa, 7'b1000100);
    cyc(0, 0, 0); chk("dmp_c3_idle", oa, 7'b0000000);

    // Both held: acked requester loses its ack-cycle vote, so grants alternate
    cyc(1, 1, 0); chk("both_c0", oa, 7'b0000011);
    cyc(1, 1, 0); chk("both_c1_dm", oa, 7'b1100011);
    cyc(1, 1, 0); chk("both_c2_dmack", oa, 7'b1000110);
    cyc(1, 1, 0); chk("both_c3_if", oa, 7'b0100011);
    cyc(1, 1, 0); chk("both_c4_ifack", oa, 7'b0001001);
    cyc(1, 1, 0); chk("both_c5_dm", oa, 7'b1100011);
    cyc(0, 0, 0); chk("both_c6_dmack", oa, 7'b1000100);
    cyc(0, 0, 0); chk("both_c7_idle", oa, 7'b0000000);

    // Starvation guard: starve count is 1 here; two more DM wins over a waiting IF
    // bring it to 3, after which IF must win the next contested arbitration.
    for (int r = 0; r < 2; r++) begin
      cyc(1, 1, 0); chk("starve_idle", oa, 7'b0000011);
      cyc(1, 1, 0); chk("starve_dm", oa, 7'b1100011);
      cyc(0, 1, 0); chk("starve_dmack", oa, 7'b1000100);
    end
    cyc(1, 1, 0); chk("guard_idle", oa, 7'b0000011);
    cyc(1, 1, 0); chk("guard_if_wins", oa, 7'b0100011);
    cyc(0, 0, 0); chk("guard_ifack", oa, 7'b0001000);
    cyc(0, 0, 0); chk("guard_idle2", oa, 7'b0000000);

    // Asynchronous reset in the middle of a DM access
    cyc(0, 1, 1); chk("rst_c0", oa, 7'b0000001);
    cyc(0, 1, 1); chk("rst_c1", oa, 7'b1110001);
    #1; rst = 1'b1; dm_req = 1'b0; dm_we = 1'b0;
    #1; chk("rst_async", oa, 7'b0000000);
    cyc(0, 0, 0); chk("rst_no_ack", oa, 7'b0000000);
    rst = 1'b0;
    cyc(0, 1, 0); chk("rst_fresh_c0", oa, 7'b0000001);
    cyc(0, 1, 0); chk("rst_fresh_c1", oa, 7'b1100001);
    cyc(0, 0, 0); chk("rst_fresh_ack", oa, 7'b1000100);
    cyc(0, 0, 0); chk("rst_fresh_idle", oa, 7'b0000000);
    cyc(0, 0, 0); chk("b_idle", ob, 7'b0000000);

    // MEM_LAT = 1: strobe and ack coincide, grants alternate each cycle
    cyc(1, 1, 0); chk("lat1_c0", ob, 7'b0000011);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 1, 0); chk("lat1_dm", ob, 7'b1100110);
      cyc(1, 1, 0); chk("lat1_if", ob, 7'b0101001);
    end
    cyc(0, 0, 0); chk("lat1_last_dm", ob, 7'b1100100);
    cyc(0, 0, 0); chk("lat1_idle", ob, 7'b0000000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
